// File: rtl/tt_um_freq_meter.sv
// Gated frequency counter: counts rising edges of ui_in[0] over an N-cycle window
// and holds the last complete count for byte-wise readout on uo_out.
module tt_um_freq_meter #(
  parameter int GATE_CYCLES = 60000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int GATE_SHORT = GATE_CYCLES / 10;
  localparam int GW         = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    LAST_LONG  = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    LAST_SHORT = GW'(GATE_SHORT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_s1, r_in_s2, r_in_prev;
  logic             r_clr_s1, r_clr_s2;
  logic             r_gsel_s1, r_gsel_s2;
  logic [1:0]       r_settle;
  logic             r_short;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_win_ovf;
  logic [CNT_W-1:0] r_result;
  logic             r_valid;
  logic             r_ovf;

  logic             w_edge_now;
  logic             w_cnt_sat;
  logic             w_terminal;
  logic [31:0]      w_res_ext;
  logic             w_unused;

  assign w_edge_now = r_in_s2 & ~r_in_prev;
  assign w_cnt_sat  = (r_edge_cnt == CNT_MAX);
  assign w_terminal = (r_state == S_GATE) &&
                      (r_gate_cnt == (r_short ? LAST_SHORT : LAST_LONG));
  assign w_unused   = &{1'b0, ena, uio_in, ui_in[7:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_settle == 2'd2) w_state_nxt = S_GATE;
      S_GATE:   w_state_nxt = S_GATE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // A synchronized clear overrides every transition, including the terminal cycle.
    if (r_clr_s2) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_s1    <= 1'b0;
      r_in_s2    <= 1'b0;
      r_in_prev  <= 1'b0;
      r_clr_s1   <= 1'b0;
      r_clr_s2   <= 1'b0;
      r_gsel_s1  <= 1'b0;
      r_gsel_s2  <= 1'b0;
      r_settle   <= 2'd0;
      r_short    <= 1'b0;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_win_ovf  <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_in_s1   <= ui_in[0];
      r_in_s2   <= r_in_s1;
      r_in_prev <= r_in_s2;
      r_clr_s1  <= ui_in[3];
      r_clr_s2  <= r_clr_s1;
      r_gsel_s1 <= ui_in[4];
      r_gsel_s2 <= r_gsel_s1;
      if (r_clr_s2) begin
        r_settle   <= 2'd0;
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_win_ovf  <= 1'b0;
        r_result   <= '0;
        r_valid    <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_settle   <= 2'd0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
          end
          S_SETTLE: begin
            if (r_settle == 2'd2) begin
              r_settle <= 2'd0;
              r_short  <= r_gsel_s2;
            end else begin
              r_settle <= r_settle + 2'd1;
            end
          end
          S_GATE: begin
            if (w_terminal) begin
              // Fold in this cycle's edge so the window spans exactly N samples.
              r_result   <= w_cnt_sat ? CNT_MAX : r_edge_cnt + CNT_W'(w_edge_now);
              r_ovf      <= r_win_ovf | (w_cnt_sat & w_edge_now);
              r_valid    <= 1'b1;
              r_gate_cnt <= '0;
              r_edge_cnt <= '0;
              r_win_ovf  <= 1'b0;
              r_short    <= r_gsel_s2;
            end else begin
              r_gate_cnt <= r_gate_cnt + GW'(1);
              if (w_edge_now) begin
                if (w_cnt_sat) r_win_ovf  <= 1'b1;
                else           r_edge_cnt <= r_edge_cnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_res_ext = 32'(r_result);

  always_comb begin
    uo_out = 8'h00;
    case (ui_in[2:1])
      2'd0: uo_out = w_res_ext[7:0];
      2'd1: uo_out = w_res_ext[15:8];
      2'd2: uo_out = w_res_ext[23:16];
      2'd3: uo_out = w_res_ext[31:24];
      default: uo_out = 8'h00;
    endcase
  end

  assign uio_out = {6'b000000, r_ovf, r_valid};
  assign uio_oe  = 8'h03;

endmodule

// File: tb/tb_tt_um_freq_meter.sv
// Bench for tt_um_freq_meter: three instances (100/26, 100/4, 700/26) driven in
// parallel and compared every cycle against a window-level edge-count model.
module tb_tt_um_freq_meter;

  localparam int M26 = (1 << 26) - 1;
  localparam int HMAX = 4095;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_a, uio_a, oe_a;
  logic [7:0] uo_b, uio_b, oe_b;
  logic [7:0] uo_c, uio_c, oe_c;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit hist_in [0:HMAX];
  bit hist_g  [0:HMAX];
  bit hist_c  [0:HMAX];
  int gen_period = 0;
  int gen_t = 0;
  int gen_phase = 0;
  logic [47:0] exp_all;

  always #5 clk = ~clk;

  tt_um_freq_meter #(.GATE_CYCLES(100), .CNT_W(26)) u_w26 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_a),
    .uio_in(uio_in), .uio_out(uio_a), .uio_oe(oe_a));
  tt_um_freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_b),
    .uio_in(uio_in), .uio_out(uio_b), .uio_oe(oe_b));
  tt_um_freq_meter #(.GATE_CYCLES(700), .CNT_W(26)) u_big (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_c),
    .uio_in(uio_in), .uio_out(uio_c), .uio_oe(oe_c));

  // Input history indexed by clock edge number since reset release (edge 1 = first).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else if (cyc < HMAX) begin
      cyc <= cyc + 1;
      hist_in[cyc + 1] <= ui_in[0];
      hist_g[cyc + 1]  <= ui_in[4];
      hist_c[cyc + 1]  <= ui_in[3];
    end
  end

  function automatic bit in_at(input int k);
    if (k < 1 || k > HMAX) return 1'b0;
    return hist_in[k];
  endfunction
  function automatic bit g_at(input int k);
    if (k < 1 || k > HMAX) return 1'b0;
    return hist_g[k];
  endfunction
  function automatic bit c_at(input int k);
    if (k < 1 || k > HMAX) return 1'b0;
    return hist_c[k];
  endfunction

  // Expected {uio_out, uo_out} after edge e. Inputs reach the logic two edges late;
  // a window starts four edges after the block leaves clear, lasts N edges, and
  // the next window follows at once. Any clear seen inside aborts and zeroes.
  function automatic logic [15:0] model_out(input int e, input int n_long,
                                            input int maxv, input logic [1:0] sel);
    int res, j, s, prev, n, t, last, cnt, kab;
    bit val, ovf, done;
    logic [7:0] b;
    res = 0; val = 0; ovf = 0; j = 1; done = 0;
    while (!done) begin
      while (j <= e && c_at(j - 2)) j++;
      if (j > e) done = 1;
      else begin
        s = j + 4; prev = j; kab = 0;
        while (!done && kab == 0) begin
          n = (s - 3 <= e) ? (g_at(s - 3) ? n_long / 10 : n_long) : (1 << 20);
          t = s + n - 1;
          last = (t < e) ? t : e;
          for (int k = prev + 1; k <= last; k++)
            if (kab == 0 && c_at(k - 2)) kab = k;
          if (kab != 0) begin
            res = 0; val = 0; ovf = 0; j = kab + 1;
          end else if (t > e) begin
            done = 1;
          end else begin
            cnt = 0;
            for (int k = s - 2; k <= t - 2; k++)
              if (in_at(k) && !in_at(k - 1)) cnt++;
            res = (cnt > maxv) ? maxv : cnt;
            ovf = (cnt > maxv);
            val = 1;
            prev = t; s = t + 1;
          end
        end
      end
    end
    b = 8'((res >> (8 * int'(sel))) & 255);
    return {6'b000000, ovf, val, b};
  endfunction

  function automatic logic [47:0] model_all();
    return {model_out(cyc, 100, M26, ui_in[2:1]), model_out(cyc, 100, 15, ui_in[2:1]),
            model_out(cyc, 700, M26, ui_in[2:1])};
  endfunction

  // Called at a negedge: drive the next input sample, advance one clock, return at the next negedge.
  task automatic tick();
    if (gen_period > 0) begin
      ui_in[0] = (((gen_t + gen_phase) % gen_period) < (gen_period / 2));
      gen_t++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gen_t = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ui_in = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({uo_a, uio_a, oe_a, uo_b, uio_b, oe_b, uo_c, uio_c, oe_c} !==
          {8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03}) begin
        errors++;
        $display("FAIL reset i=%0d got uo=%h uio=%h oe=%h exp 00/00/03", i, uo_a, uio_a, oe_a);
      end
    end
  endtask

  task automatic test_long_gate();
    ui_in = 8'h00;
    gen_period = 10; gen_phase = $urandom_range(0, 9);
    do_reset();
    for (int i = 0; i < 404; i++) begin
      tick();
      exp_all = model_all();
      checks++;
      if ({uio_a, uo_a, uio_b, uo_b, uio_c, uo_c} !== exp_all) begin
        errors++;
        $display("FAIL long_gate cyc=%0d got=%h exp=%h", cyc,
                 {uio_a, uo_a, uio_b, uo_b, uio_c, uo_c}, exp_all);
      end
      if (cyc == 103) begin
        checks++;
        if (uio_a !== 8'h00) begin
          errors++;
          $display("FAIL long_gate_early cyc=%0d uio=%h exp 00", cyc, uio_a);
        end
      end
      if (cyc % 100 == 4 && cyc > 100) begin
        checks++;
        if (uo_a !== 8'h0A || uio_a !== 8'h01) begin
          errors++;
          $display("FAIL long_gate_count cyc=%0d uo=%h uio=%h exp 0a/01", cyc, uo_a, uio_a);
        end
      end
    end
  endtask

  task automatic test_short_gate();
    ui_in = 8'h10;
    gen_period = 4; gen_phase = $urandom_range(0, 3);
    do_reset();
    for (int i = 0; i < 150; i++) begin
      tick();
      if (cyc == 37) ui_in[4] = 1'b0;
      exp_all = model_all();
      checks++;
      if ({uio_a, uo_a, uio_b, uo_b, uio_c, uo_c} !== exp_all) begin
        errors++;
        $display("FAIL short_gate cyc=%0d got=%h exp=%h", cyc,
                 {uio_a, uo_a, uio_b, uo_b, uio_c, uo_c}, exp_all);
      end
      if (cyc == 14 || cyc == 24 || cyc == 34 || cyc == 44) begin
        checks++;
        if (!(uo_a == 8'd2 || uo_a == 8'd3) || uio_a !== 8'h01) begin
          errors++;
          $display("FAIL short_gate_range cyc=%0d uo=%h uio=%h exp 2..3/01", cyc, uo_a, uio_a);
        end
      end
      if (cyc == 144) begin
        checks++;
        if (uo_a !== 8'd25) begin
          errors++;
          $display("FAIL short_to_long cyc=%0d uo=%h exp 19", cyc, uo_a);
        end
      end
    end
  endtask

  task automatic test_overflow();
    ui_in = 8'h00;
    gen_period = 4; gen_phase = $urandom_range(0, 3);
    do_reset();
    for (int i = 0; i < 210; i++) begin
      tick();
      if (cyc == 99) begin
        gen_period = 10; gen_t = 0; gen_phase = 0;
      end
      exp_all = model_all();
      checks++;
      if ({uio_a, uo_a, uio_b, uo_b, uio_c, uo_c} !== exp_all) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%h exp=%h", cyc,
                 {uio_a, uo_a, uio_b, uo_b, uio_c, uo_c}, exp_all);
      end
      if (cyc == 104) begin
        checks++;
        if (uo_b !== 8'h0F || uio_b !== 8'h03) begin
          errors++;
          $display("FAIL overflow_sat uo=%h uio=%h exp 0f/03", uo_b, uio_b);
        end
      end
      if (cyc == 204) begin
        checks++;
        if (uo_b !== 8'h0A || uio_b !== 8'h01) begin
          errors++;
          $display("FAIL overflow_recover uo=%h uio=%h exp 0a/01", uo_b, uio_b);
        end
      end
    end
  endtask

  task automatic test_clear();
    int c1, p;
    ui_in = 8'h00;
    p = $urandom_range(5, 12);
    gen_period = p; gen_phase = $urandom_range(0, p - 1);
    do_reset();
    c1 = 0;
    for (int i = 0; i < 260; i++) begin
      if (cyc == 130) begin c1 = cyc + 1; ui_in[3] = 1'b1; end
      if (c1 != 0 && cyc == c1 + 2) ui_in[3] = 1'b0;
      tick();
      exp_all = model_all();
      checks++;
      if ({uio_a, uo_a, uio_b, uo_b, uio_c, uo_c} !== exp_all) begin
        errors++;
        $display("FAIL clear cyc=%0d got=%h exp=%h", cyc,
                 {uio_a, uo_a, uio_b, uo_b, uio_c, uo_c}, exp_all);
      end
      if (c1 != 0 && (cyc == c1 + 2 || cyc == c1 + 107)) begin
        checks++;
        if (uio_a !== 8'h00 || (cyc == c1 + 2 && uo_a !== 8'h00)) begin
          errors++;
          $display("FAIL clear_zero cyc=%0d uo=%h uio=%h exp 00/00", cyc, uo_a, uio_a);
        end
      end
      if (c1 != 0 && cyc == c1 + 108) begin
        checks++;
        if (uio_a !== 8'h01 || int'(uo_a) < 100 / p || int'(uo_a) > (100 + p - 1) / p) begin
          errors++;
          $display("FAIL clear_restart cyc=%0d uo=%0d uio=%h period=%0d", cyc, uo_a, uio_a, p);
        end
      end
    end
  endtask

  task automatic test_byte_select();
    int rises;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h23; exp_b[1] = 8'h01; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    ui_in = 8'h00;
    gen_period = 0;
    rises = 0;
    do_reset();
    while (cyc < 754) begin
      if (cyc >= 2 && rises < 291) begin
        ui_in[0] = ~ui_in[0];
        if (ui_in[0]) rises++;
      end else begin
        ui_in[0] = 1'b0;
      end
      tick();
      exp_all = model_all();
      checks++;
      if ({uio_a, uo_a, uio_b, uo_b, uio_c, uo_c} !== exp_all) begin
        errors++;
        $display("FAIL byte_sel_run cyc=%0d got=%h exp=%h", cyc,
                 {uio_a, uo_a, uio_b, uo_b, uio_c, uo_c}, exp_all);
      end
      if (cyc == 704) begin
        for (int s = 0; s < 4; s++) begin
          ui_in[2:1] = 2'(s);
          #1;
          checks++;
          if (uo_c !== exp_b[s] || uio_c !== 8'h01) begin
            errors++;
            $display("FAIL byte_sel s=%0d uo=%h uio=%h exp %h/01", s, uo_c, uio_c, exp_b[s]);
          end
        end
        ui_in[2:1] = 2'd0;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({uo_a, uio_a, oe_a, uo_b, uio_b, oe_b, uo_c, uio_c, oe_c} !==
        {8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03}) begin
      errors++;
      $display("FAIL async_reset uo=%h uio=%h uo_big=%h uio_big=%h", uo_a, uio_a, uo_c, uio_c);
    end
    @(negedge clk);
  endtask

  task automatic test_random_traffic();
    ui_in = 8'h00;
    gen_period = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      ui_in[0] = 1'($urandom);
      ui_in[2:1] = 2'($urandom);
      if ($urandom_range(0, 59) == 0) ui_in[4] = ~ui_in[4];
      ui_in[3] = ($urandom_range(0, 249) == 0);
      tick();
      exp_all = model_all();
      checks++;
      if ({uio_a, uo_a, uio_b, uo_b, uio_c, uo_c} !== exp_all) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                 {uio_a, uo_a, uio_b, uo_b, uio_c, uo_c}, exp_all);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    #1 rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_long_gate();
    test_short_gate();
    test_overflow();
    test_clear();
    test_byte_select();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
